// File: rtl/mode_counter_pkg.sv
// Shared mode encodings and decode helper for mode_counter.
// Reserved mode 2'b11 decodes to wrap.
package mode_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PINGPONG = 2'b10
  } mode_e;

  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_ONESHOT;
      2'b10:   return MODE_PINGPONG;
      default: return MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/mode_counter_prescaler.sv
// Divides cnt_en by PRESCALE; tick marks the enabled cycle that closes a group.
// Used by mode_counter only when MODE_COUNTER_PRESCALE_EN is defined.
module mode_counter_prescaler
  import mode_counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clock50,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  assign tick = en && (pcnt == LAST);

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Up/down counter with runtime limit, load and wrap/one-shot/ping-pong modes.
// Optional cnt_en prescaler: define MODE_COUNTER_PRESCALE_EN.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH         = 5,
  parameter int DEFAULT_LIMIT = 25,
  parameter int PRESCALE      = 4
) (
  input  logic             clock50,
  input  logic             reset,
  input  logic             cnt_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir_down,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic             dir_out
);

  logic             step;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;
  logic             going_down;
  logic             term;
  logic             live;
  mode_e            md;

`ifdef MODE_COUNTER_PRESCALE_EN
  mode_counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock50(clock50),
    .reset  (reset),
    .clr    (load),
    .en     (cnt_en),
    .tick   (step)
  );
`else
  assign step = cnt_en & (PRESCALE > 0);
`endif

  assign md = decode_mode(mode);

  // Ping-pong owns its direction; other modes follow dir_down live.
  assign going_down = (md == MODE_PINGPONG) ? dir_q : dir_down;
  assign term = going_down ? (count_q == '0) : (count_q >= limit_q);
  assign live = !load && step && !(md == MODE_ONESHOT && done_q);

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      limit_q <= WIDTH'(DEFAULT_LIMIT);
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    unique case (1'b1)
      load: begin
        count_d = load_val;
        limit_d = limit;
        done_d  = 1'b0;
        dir_d   = dir_down;
      end
      live: begin
        if (md != MODE_PINGPONG) dir_d = dir_down;
        if (!term) begin
          count_d = going_down ? count_q - 1'b1 : count_q + 1'b1;
        end else begin
          tc_d    = 1'b1;
          limit_d = limit;
          case (md)
            MODE_ONESHOT: done_d = 1'b1;
            MODE_PINGPONG: begin
              dir_d = !going_down;
              if (limit_q == '0) count_d = '0;
              else count_d = going_down ? WIDTH'(1) : count_q - 1'b1;
            end
            default: count_d = going_down ? limit_q : '0;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign done    = done_q;
  assign dir_out = dir_q;

endmodule

// File: tb/tb_mode_counter.sv
// Directed scoreboard bench for mode_counter (default parameters).
// Expected {count,tc,done,dir_out} is queued at drive time and checked after the edge.
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_en;
  logic       load;
  logic [4:0] load_val;
  logic       dir_down;
  logic [1:0] mode;
  logic [4:0] limit;
  logic [4:0] count;
  logic       tc;
  logic       done;
  logic       dir_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  mode_counter dut (
    .clock50 (clk),
    .reset   (rst),
    .cnt_en  (cnt_en),
    .load    (load),
    .load_val(load_val),
    .dir_down(dir_down),
    .mode    (mode),
    .limit   (limit),
    .count   (count),
    .tc      (tc),
    .done    (done),
    .dir_out (dir_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check_now(input logic [7:0] e, input string t);
    logic [7:0] obs;
    obs = {count, tc, done, dir_out};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic cyc(
    input logic en, input logic ld, input logic [4:0] lv,
    input logic dd, input logic [1:0] md, input logic [4:0] lim,
    input logic [4:0] ec, input logic etc, input logic ed,
    input logic edir, input string tag
  );
    logic [7:0] e;
    string t;
    cnt_en = en; load = ld; load_val = lv;
    dir_down = dd; mode = md; limit = lim;
    exp_q.push_back({ec, etc, ed, edir});
    tag_q.push_back(tag);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_now(e, t);
  endtask

  initial begin
    rst = 1'b1; cnt_en = 0; load = 0; load_val = 0;
    dir_down = 0; mode = 2'b00; limit = 5'd25;
    #3;
    check_now(8'h00, "reset_state");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i <= 17; i++)
      cyc(1, 0, 0, 0, 0, 25, 5'(i), 0, 0, 0, "count_to_17");
    #2 rst = 1'b1;
    #1 check_now(8'h00, "async_reset_mid");
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 1; i <= 25; i++)
      cyc(1, 0, 0, 0, 0, 25, 5'(i), 0, 0, 0, "after_reset_up");
    cyc(1, 0, 0, 0, 0, 25, 0, 1, 0, 0, "default_limit_wrap");
    for (int i = 1; i <= 25; i++)
      cyc(1, 0, 0, 0, 0, 25, 5'(i), 0, 0, 0, "wrap_period");
    cyc(1, 0, 0, 0, 0, 25, 0, 1, 0, 0, "wrap_26");

    cyc(1, 0, 0, 1, 0, 25, 25, 1, 0, 1, "down_wrap");
    cyc(1, 0, 0, 1, 0, 25, 24, 0, 0, 1, "down_step");

    cyc(0, 1, 20, 0, 0, 10, 20, 0, 0, 0, "load_20_lim10");
    cyc(1, 0, 0, 0, 0, 10, 0, 1, 0, 0, "ge_wrap_20");
    for (int i = 1; i <= 10; i++)
      cyc(1, 0, 0, 0, 0, 10, 5'(i), 0, 0, 0, "period_11");
    cyc(1, 0, 0, 0, 0, 10, 0, 1, 0, 0, "wrap_at_10");
    for (int i = 1; i <= 5; i++)
      cyc(1, 0, 0, 0, 0, 10, 5'(i), 0, 0, 0, "to_5");
    for (int i = 6; i <= 10; i++)
      cyc(1, 0, 0, 0, 0, 25, 5'(i), 0, 0, 0, "old_limit_kept");
    cyc(1, 0, 0, 0, 0, 25, 0, 1, 0, 0, "still_wrap_10");
    for (int i = 1; i <= 25; i++)
      cyc(1, 0, 0, 0, 0, 25, 5'(i), 0, 0, 0, "new_limit_25");
    cyc(1, 0, 0, 0, 0, 25, 0, 1, 0, 0, "wrap_at_25");

    cyc(0, 1, 3, 0, 1, 6, 3, 0, 0, 0, "os_load");
    cyc(1, 0, 0, 0, 1, 6, 4, 0, 0, 0, "os_4");
    cyc(1, 0, 0, 0, 1, 6, 5, 0, 0, 0, "os_5");
    cyc(1, 0, 0, 0, 1, 6, 6, 0, 0, 0, "os_6");
    cyc(1, 0, 0, 0, 1, 6, 6, 1, 1, 0, "os_done_tc");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 1, 6, 6, 0, 1, 0, "os_no_more_tc");
    cyc(0, 1, 3, 0, 1, 6, 3, 0, 0, 0, "os_load_clears");

    cyc(0, 1, 0, 0, 2, 3, 0, 0, 0, 0, "pp_load");
    cyc(1, 0, 0, 0, 2, 3, 1, 0, 0, 0, "pp_1");
    cyc(1, 0, 0, 0, 2, 3, 2, 0, 0, 0, "pp_2");
    cyc(1, 0, 0, 0, 2, 3, 3, 0, 0, 0, "pp_3");
    cyc(1, 0, 0, 0, 2, 3, 2, 1, 0, 1, "pp_turn_down");
    cyc(1, 0, 0, 0, 2, 3, 1, 0, 0, 1, "pp_down_1");
    cyc(1, 0, 0, 1, 2, 3, 0, 0, 0, 1, "pp_down_0");
    cyc(1, 0, 0, 1, 2, 3, 1, 1, 0, 0, "pp_turn_up");
    cyc(0, 1, 0, 0, 2, 0, 0, 0, 0, 0, "pp_lim0_load");
    cyc(1, 0, 0, 0, 2, 0, 0, 1, 0, 1, "pp_lim0_a");
    cyc(1, 0, 0, 0, 2, 0, 0, 1, 0, 0, "pp_lim0_b");
    cyc(1, 0, 0, 0, 2, 0, 0, 1, 0, 1, "pp_lim0_c");

    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "wrap_lim0_load");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "wrap_lim0_a");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "wrap_lim0_b");

    cyc(0, 1, 24, 0, 0, 25, 24, 0, 0, 0, "load_24");
    cyc(1, 1, 7, 0, 0, 25, 7, 0, 0, 0, "load_beats_step");
    cyc(0, 0, 0, 0, 0, 25, 7, 0, 0, 0, "hold_no_en");
    cyc(0, 1, 25, 0, 3, 25, 25, 0, 0, 0, "rsvd_load");
    cyc(1, 0, 0, 0, 3, 25, 0, 1, 0, 0, "rsvd_as_wrap");

`ifdef MODE_COUNTER_PRESCALE_EN
    cyc(0, 1, 0, 0, 0, 25, 0, 0, 0, 0, "ps_load");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 0, 25, 0, 0, 0, 0, "ps_wait");
    cyc(0, 0, 0, 0, 0, 25, 0, 0, 0, 0, "ps_gap");
    cyc(1, 0, 0, 0, 0, 25, 1, 0, 0, 0, "ps_step_1");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 0, 25, 1, 0, 0, 0, "ps_wait2");
    cyc(1, 0, 0, 0, 0, 25, 2, 0, 0, 0, "ps_step_2");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
